// File: rtl/ahfp_pkg.sv
// Shared float-format constants and the packed single-precision layout
// used by the fixed-to-float conversion pipeline.
package ahfp_pkg;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_W    = 8;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/ahfp_fixed_2_float_if.sv
// Valid/ready stream bundle for the fixed-to-float converter: one input
// stream of fixed-point operands and one output stream of float results.
interface ahfp_fixed_2_float_if;

    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

endinterface

// File: rtl/ahfp_lzc32.sv
// Combinational 32-bit leading-zero counter; reports 32 for an all-zero word.
module ahfp_lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) count = 6'(31 - i);
        end
    end

endmodule

// File: rtl/ahfp_fixed_2_float.sv
// Signed fixed-point to IEEE-754 single converter: a 3-stage pipeline
// (magnitude, MSB search, normalise/round/pack) behind valid/ready streams.
module ahfp_fixed_2_float
    import ahfp_pkg::*;
#(
    parameter int FRAC_BITS = 29
) (
    input  logic                 clk,
    input  logic                 reset,
    ahfp_fixed_2_float_if.slave  bus
);

    localparam logic [FP_EXP_W-1:0] EXP_OFFSET = FP_EXP_W'(FP_EXP_BIAS - FRAC_BITS);

    logic        en;
    logic        s1_valid, s1_sign;
    logic [31:0] s1_mag;
    logic [5:0]  lzc_count;
    logic        s2_valid, s2_sign, s2_zero;
    logic [31:0] s2_mag;
    logic [4:0]  s2_msb;
    logic        out_valid_q;
    logic [31:0] out_data_q;

    logic [30:0]          norm;
    logic [FP_MANT_W-1:0] mant_raw;
    logic                 guard, sticky, round_up;
    logic [FP_MANT_W:0]   mant_sum;
    fp32_t                packed_res;

    // Whole pipeline advances together; a stalled output freezes every stage.
    assign en            = !out_valid_q | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= bus.in_data[31];
            s1_mag   <= bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;
        end
    end

    ahfp_lzc32 u_lzc (
        .value (s1_mag),
        .count (lzc_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mag   <= s1_mag;
            s2_msb   <= 5'd31 - lzc_count[4:0];
            s2_zero  <= lzc_count[5];
        end
    end

    // Bit 31 of the shifted word is the implicit leading one and is dropped.
    always_comb begin
        norm       = 31'(s2_mag << (5'd31 - s2_msb));
        mant_raw   = norm[30:8];
        guard      = norm[7];
        sticky     = |norm[6:0];
        round_up   = guard & (sticky | mant_raw[0]);
        mant_sum   = {1'b0, mant_raw} + (FP_MANT_W+1)'(round_up);
        packed_res = '0;
        if (!s2_zero) begin
            packed_res.sign = s2_sign;
            packed_res.exp  = EXP_OFFSET + {3'b000, s2_msb} + {7'b0000000, mant_sum[FP_MANT_W]};
            packed_res.mant = mant_sum[FP_MANT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
        end else if (en) begin
            out_valid_q <= s2_valid;
            out_data_q  <= packed_res;
        end
    end

endmodule

// File: tb/tb_ahfp_fixed_2_float.sv
// Directed self-checking bench for ahfp_fixed_2_float with FRAC_BITS=29.
module tb_ahfp_fixed_2_float;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ahfp_fixed_2_float_if bus ();

    ahfp_fixed_2_float #(.FRAC_BITS(29)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Sends one operand with out_ready high and waits (bounded) for its result.
    task automatic applyStimulus(input logic [31:0] d, output logic [31:0] res,
                                 output int lat, output bit got);
        bus.in_data   = d;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        res = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                res = bus.out_data;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_out_data got %h expected 00000000", bus.out_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic;
        logic [31:0] vin  [2];
        logic [31:0] vexp [2];
        logic [31:0] res;
        int lat;
        bit got;
        vin  = '{32'h20000000, 32'h10000000};
        vexp = '{32'h3F800000, 32'h3F000000};
        for (int i = 0; i < 2; i++) begin
            applyStimulus(vin[i], res, lat, got);
            checks++;
            if (!got || res !== vexp[i]) begin
                errors++;
                $display("[TB] FAIL basic[%0d] in %h got %h (valid seen %0b) expected %h",
                         i, vin[i], res, got, vexp[i]);
            end
            if (i == 0) begin
                checks++;
                if (lat !== 3) begin
                    errors++;
                    $display("[TB] FAIL latency got %0d expected 3", lat);
                end
            end
        end
        idle(4);
    endtask

    task automatic test_signs;
        logic [31:0] vin  [3];
        logic [31:0] vexp [3];
        logic [31:0] res;
        int lat;
        bit got;
        vin  = '{32'hE0000000, 32'h80000000, 32'h00000000};
        vexp = '{32'hBF800000, 32'hC0800000, 32'h00000000};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vin[i], res, lat, got);
            checks++;
            if (!got || res !== vexp[i]) begin
                errors++;
                $display("[TB] FAIL signs[%0d] in %h got %h (valid seen %0b) expected %h",
                         i, vin[i], res, got, vexp[i]);
            end
        end
        idle(4);
    endtask

    task automatic test_rounding;
        logic [31:0] vin  [4];
        logic [31:0] vexp [4];
        logic [31:0] res;
        int lat;
        bit got;
        vin  = '{32'h20000020, 32'h20000060, 32'h7FFFFFFF, 32'h00000001};
        vexp = '{32'h3F800000, 32'h3F800002, 32'h40800000, 32'h31000000};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vin[i], res, lat, got);
            checks++;
            if (!got || res !== vexp[i]) begin
                errors++;
                $display("[TB] FAIL rounding[%0d] in %h got %h (valid seen %0b) expected %h",
                         i, vin[i], res, got, vexp[i]);
            end
        end
        idle(4);
    endtask

    task automatic test_back_to_back;
        logic [31:0] vin  [8];
        logic [31:0] vexp [8];
        logic [31:0] outs [8];
        int cyc [8];
        int n = 0;
        vin  = '{32'h20000000, 32'h40000000, 32'h30000000, 32'hF0000000,
                 32'h08000000, 32'h00000000, 32'h60000000, 32'hD0000000};
        vexp = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'hBF000000,
                 32'h3E800000, 32'h00000000, 32'h40400000, 32'hBFC00000};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (c < 8);
            if (c < 8) bus.in_data = vin[c];
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (n < 8) begin
                    outs[n] = bus.out_data;
                    cyc[n]  = c;
                end
                n++;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (n !== 8) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d expected 8", n);
        end
        checks++;
        if (n >= 1 && cyc[0] !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_first_cycle got %0d expected 2", cyc[0]);
        end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++;
            if (outs[i] !== vexp[i] || cyc[i] !== cyc[0] + i) begin
                errors++;
                $display("[TB] FAIL b2b[%0d] got %h at cycle %0d expected %h at cycle %0d",
                         i, outs[i], cyc[i], vexp[i], cyc[0] + i);
            end
        end
        idle(4);
    endtask

    task automatic test_backpressure;
        logic [31:0] vin  [8];
        logic [31:0] vexp [8];
        logic [31:0] outs [8];
        logic [31:0] held = '0;
        bit have_held = 1'b0;
        bit accepted;
        int idx = 0;
        int n = 0;
        int stall_seen = 0;
        vin  = '{32'h60000000, 32'hD0000000, 32'h20000000, 32'h7FFFFFFF,
                 32'h00000000, 32'h20000060, 32'hE0000000, 32'h08000000};
        vexp = '{32'h40400000, 32'hBFC00000, 32'h3F800000, 32'h40800000,
                 32'h00000000, 32'h3F800002, 32'hBF800000, 32'h3E800000};
        for (int c = 0; c < 30; c++) begin
            bus.in_valid = (idx < 8);
            if (idx < 8) bus.in_data = vin[idx];
            bus.out_ready = !(c >= 4 && c < 9);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                stall_seen++;
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_in_ready cycle %0d got %b expected 0", c, bus.in_ready);
                end
                if (have_held) begin
                    checks++;
                    if (bus.out_data !== held) begin
                        errors++;
                        $display("[TB] FAIL bp_stable cycle %0d got %h expected %h",
                                 c, bus.out_data, held);
                    end
                end
                held      = bus.out_data;
                have_held = 1'b1;
            end
            accepted = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                if (n < 8) outs[n] = bus.out_data;
                n++;
            end
            @(posedge clk); #1;
            if (accepted) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (stall_seen !== 5) begin
            errors++;
            $display("[TB] FAIL bp_stall_cycles got %0d expected 5", stall_seen);
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("[TB] FAIL bp_count got %0d expected 8", n);
        end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++;
            if (outs[i] !== vexp[i]) begin
                errors++;
                $display("[TB] FAIL bp[%0d] got %h expected %h", i, outs[i], vexp[i]);
            end
        end
        idle(4);
    endtask

    task automatic test_reset_inflight;
        logic [31:0] vin [3];
        int stale = 0;
        vin = '{32'h20000000, 32'hE0000000, 32'h7FFFFFFF};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vin[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_fly_out_valid got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_fly_out_data got %h expected 00000000", bus.out_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_fly_in_ready got %b expected 1", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) stale++;
            @(posedge clk); #1;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("[TB] FAIL rst_fly_stale got %0d valid cycles expected 0", stale);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        test_reset();
        test_basic();
        test_signs();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
